// File: rtl/spm_pkg.sv
// spm_pkg: shared types and helpers for the serial-parallel multiplier.
//   state_t : controller states (IDLE waits for start, RUN streams the product)
//   cnt_w   : width of the cycle counter needed to count 0..2*width inclusive
package spm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter has to reach 2*width without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// spm_csa_cell: one-bit carry-save cell of the serial-parallel multiplier.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears sum and carry
//   clr    : synchronous clear at the start of an operation
//   en     : advance the cell by one serial step
//   x_bit  : this cell's multiplicand bit
//   s      : current serial multiplier bit, shared by all cells
//   sum_in : registered sum of the next-higher cell (or the top-cell input)
//   sum    : registered sum, passed down to the next-lower cell
//   carry  : registered carry, fed back into this cell on the next step
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x_bit,
  input  logic s,
  input  logic sum_in,
  output logic sum,
  output logic carry
);

  logic pp;

  assign pp = x_bit & s;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum   <= 1'b0;
      carry <= 1'b0;
    end else if (en) begin
      sum   <= pp ^ sum_in ^ carry;
      carry <= (pp & sum_in) | (pp & carry) | (sum_in & carry);
    end
  end

endmodule

// File: rtl/spm_mult_seq.sv
// spm_mult_seq: parametrised serial-parallel multiplier.
// The multiplicand x is held in parallel; the multiplier y is shifted out
// LSB-first through a chain of WIDTH carry-save cells. One product bit falls
// out of cell 0 per step, LSB-first, for 2*WIDTH steps.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (aborts any operation)
//   start   : request, accepted only while idle (busy==0)
//   x, y    : operands, sampled at the accept edge
//   busy    : operation in progress
//   p_valid : p_bit carries a product bit this cycle
//   p_bit   : serial product bit, LSB first
//   done    : one-cycle pulse with the final p_valid
//   product : parallel product, complete while done==1 and held afterwards
module spm_mult_seq
  import spm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               p_valid,
  output logic               p_bit,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PW);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic [PW-1:0]    product_reg;

  logic             accept;
  logic             step;
  logic             s;
  logic             fill;
  logic             top_sum_in;
  logic             bit0_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_in;

  // Serial multiplier bit; once the real y bits are used up the shifter
  // supplies its fill bit, which sign-extends y in signed mode.
  assign s    = y_sh_reg[0];
  assign fill = SIGNED & y_sh_reg[WIDTH-1];

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    p_valid    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // cnt_reg==k in the cycle after step k, so the first RUN cycle
        // (cnt_reg==0) has no product bit yet.
        p_valid = (cnt_reg != '0);
        if (cnt_reg == CNT_LAST) begin
          // Final bit is on p_bit; the done cycle issues no further step.
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Carry-save cell chain
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi < WIDTH - 1) begin : g_mid
        assign sum_in[gi] = sum[gi+1];
      end else begin : g_top
        assign sum_in[gi] = top_sum_in;
      end

      spm_csa_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (step),
        .x_bit  (x_reg[gi]),
        .s      (s),
        .sum_in (sum_in[gi]),
        .sum    (sum[gi]),
        .carry  (carry[gi])
      );
    end
  endgenerate

  // Top-cell sum input. In signed mode the multiplicand's MSB has weight
  // -2^(WIDTH-1). The top cell already adds pp_top at +2^(WIDTH-1), so the
  // chain is fed -pp_top at weight 2^WIDTH: the bit stream of pp_top is
  // negated serially (copy bits up to and including the first 1, invert
  // afterwards) and registered, which aligns it one weight above the top
  // cell on the following step.
  generate
    if (SIGNED) begin : g_neg
      logic pp_top;
      logic neg_seen_reg;
      logic neg_bit_reg;

      assign pp_top = x_reg[WIDTH-1] & s;

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          neg_seen_reg <= 1'b0;
          neg_bit_reg  <= 1'b0;
        end else if (step) begin
          neg_bit_reg  <= pp_top ^ neg_seen_reg;
          neg_seen_reg <= neg_seen_reg | pp_top;
        end
      end

      assign top_sum_in = neg_bit_reg;
    end else begin : g_pos
      assign top_sum_in = 1'b0;
    end
  endgenerate

  // Value cell 0 will register on this step, i.e. the product bit that
  // becomes visible on p_bit next cycle. Shifting it into the product
  // register on the same edge keeps the parallel product complete in the
  // done cycle.
  assign bit0_next = (x_reg[0] & s) ^ sum_in[0] ^ carry[0];

  // ------------------------------------------------------------------
  // Operand registers, y shifter, counter, product shifter
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg       <= '0;
      y_sh_reg    <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      x_reg       <= x;
      y_sh_reg    <= y;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (step) begin
      y_sh_reg    <= {fill, y_sh_reg[WIDTH-1:1]};
      cnt_reg     <= cnt_reg + CW'(1);
      product_reg <= {bit0_next, product_reg[PW-1:1]};
    end
  end

  assign p_bit   = sum[0];
  assign product = product_reg;

endmodule

// File: tb/tb_spm_mult_seq.sv
// tb_spm_mult_seq: scoreboard bench for spm_mult_seq.
// Three instances: 8-bit unsigned, 8-bit signed, 32-bit signed. Expected
// products are queued when an operation is accepted and compared, both in
// parallel and as reassembled serial bits, when done fires.
module tb_spm_mult_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 8-bit unsigned instance
  logic        start_u8, busy_u8, pv_u8, pb_u8, done_u8;
  logic [7:0]  x_u8, y_u8;
  logic [15:0] prod_u8;
  // 8-bit signed instance
  logic        start_s8, busy_s8, pv_s8, pb_s8, done_s8;
  logic [7:0]  x_s8, y_s8;
  logic [15:0] prod_s8;
  // 32-bit signed instance
  logic        start_s32, busy_s32, pv_s32, pb_s32, done_s32;
  logic [31:0] x_s32, y_s32;
  logic [63:0] prod_s32;

  spm_mult_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .start(start_u8), .x(x_u8), .y(y_u8),
    .busy(busy_u8), .p_valid(pv_u8), .p_bit(pb_u8), .done(done_u8), .product(prod_u8)
  );

  spm_mult_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .start(start_s8), .x(x_s8), .y(y_s8),
    .busy(busy_s8), .p_valid(pv_s8), .p_bit(pb_s8), .done(done_s8), .product(prod_s8)
  );

  spm_mult_seq #(.WIDTH(32), .SIGNED(1'b1)) u_s32 (
    .clk(clk), .rst(rst), .start(start_s32), .x(x_s32), .y(y_s32),
    .busy(busy_s32), .p_valid(pv_s32), .p_bit(pb_s32), .done(done_s32), .product(prod_s32)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference models
  function automatic logic [15:0] mul8u(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    return p;
  endfunction

  function automatic logic [15:0] mul8s(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic logic [63:0] mul32s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Scoreboards and monitors
  logic [63:0] q_u8[$];
  logic [63:0] q_s8[$];
  logic [63:0] q_s32[$];
  logic [15:0] ser_u8, ser_s8;
  logic [63:0] ser_s32;
  int nv_u8 = 0, nv_s8 = 0, nv_s32 = 0;
  int ndone_u8 = 0, ndone_s8 = 0, ndone_s32 = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (pv_u8) begin
        ser_u8 = {pb_u8, ser_u8[15:1]};
        nv_u8++;
      end
      if (done_u8) begin
        ndone_u8++;
        chk("u8_nvalid", nv_u8, 16);
        chk("u8_done_pv", pv_u8, 1);
        nv_u8 = 0;
        chk("u8_sb_nonempty", q_u8.size() != 0, 1);
        if (q_u8.size() != 0) begin
          e = q_u8.pop_front();
          chk("u8_product", prod_u8, e);
          chk("u8_serial", ser_u8, e);
          $display("u8  done product=%04h exp=%04h", prod_u8, e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (pv_s8) begin
        ser_s8 = {pb_s8, ser_s8[15:1]};
        nv_s8++;
      end
      if (done_s8) begin
        ndone_s8++;
        chk("s8_nvalid", nv_s8, 16);
        nv_s8 = 0;
        chk("s8_sb_nonempty", q_s8.size() != 0, 1);
        if (q_s8.size() != 0) begin
          e = q_s8.pop_front();
          chk("s8_product", prod_s8, e);
          chk("s8_serial", ser_s8, e);
          $display("s8  done product=%04h exp=%04h", prod_s8, e[15:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (pv_s32) begin
        ser_s32 = {pb_s32, ser_s32[63:1]};
        nv_s32++;
      end
      if (done_s32) begin
        ndone_s32++;
        chk("s32_nvalid", nv_s32, 64);
        nv_s32 = 0;
        chk("s32_sb_nonempty", q_s32.size() != 0, 1);
        if (q_s32.size() != 0) begin
          e = q_s32.pop_front();
          chk("s32_product", prod_s32, e);
          chk("s32_serial", ser_s32, e);
          $display("s32 done product=%016h exp=%016h", prod_s32, e);
        end
      end
    end
  end

  // Stimulus helpers
  task automatic drive(input int inst, input logic st, input logic [31:0] a, input logic [31:0] b);
    case (inst)
      0: begin start_u8  = st; x_u8  = a[7:0]; y_u8  = b[7:0]; end
      1: begin start_s8  = st; x_s8  = a[7:0]; y_s8  = b[7:0]; end
      default: begin start_s32 = st; x_s32 = a; y_s32 = b; end
    endcase
  endtask

  task automatic push(input int inst, input logic [63:0] exp);
    case (inst)
      0: q_u8.push_back(exp);
      1: q_s8.push_back(exp);
      default: q_s32.push_back(exp);
    endcase
  endtask

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return busy_u8;
      1: return busy_s8;
      default: return busy_s32;
    endcase
  endfunction

  function automatic logic done_of(input int inst);
    case (inst)
      0: return done_u8;
      1: return done_s8;
      default: return done_s32;
    endcase
  endfunction

  // One full operation: accept, wait (bounded) for done, check latency and
  // that busy/done drop on the following cycle.
  task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat_exp, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, "_idle"}, busy_of(inst), 0);
    drive(inst, 1'b1, a, b);
    push(inst, exp);
    @(negedge clk);
    drive(inst, 1'b0, a, b);
    cyc = 1;
    while (!done_of(inst) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, lat_exp);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy_of(inst), 0);
    chk({tag, "_done_after"}, done_of(inst), 0);
  endtask

  initial begin
    int d0;
    logic [31:0] a, b;

    rst = 1'b1;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    drive(2, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_u8", busy_u8, 0);
    chk("rst_pv_u8", pv_u8, 0);
    chk("rst_pbit_u8", pb_u8, 0);
    chk("rst_done_u8", done_u8, 0);
    chk("rst_prod_u8", prod_u8, 0);
    chk("rst_busy_s32", busy_s32, 0);
    chk("rst_prod_s32", prod_s32, 0);
    chk("rst_busy_s8", busy_s8, 0);
    rst = 1'b0;

    // Unsigned 0xFF*0xFF with cycle-exact handshake timing.
    @(negedge clk);
    drive(0, 1'b1, 32'hFF, 32'hFF);
    push(0, 64'hFE01);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 32'hFF, 32'hFF);
      chk($sformatf("t1_busy_c%0d", c), busy_u8, (c <= 17));
      chk($sformatf("t1_pvalid_c%0d", c), pv_u8, (c >= 2 && c <= 17));
      chk($sformatf("t1_done_c%0d", c), done_u8, (c == 17));
    end
    chk("t1_prod_held", prod_u8, 16'hFE01);

    // Signed corner cases.
    run_op(1, 32'h80, 32'h80, 64'h4000, 17, "s8_min_min");
    run_op(1, 32'hFF, 32'h01, 64'hFFFF, 17, "s8_m1_one");
    run_op(1, 32'h7F, 32'h80, {48'b0, mul8s(8'h7F, 8'h80)}, 17, "s8_max_min");

    // Zero multiplicand: all serial bits zero, full latency.
    run_op(0, 32'h00, 32'hA5, 64'h0000, 17, "u8_zero");

    // Start at E0, E5 and in the done cycle: only the first is accepted.
    @(negedge clk);
    drive(0, 1'b1, 32'd3, 32'd5);
    push(0, 64'h000F);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 5 || c == 17) drive(0, 1'b1, 32'd7, 32'd9);
      else drive(0, 1'b0, 32'd7, 32'd9);
      if (c == 17) chk("t4_done_c17", done_u8, 1);
    end
    chk("t4_busy_c18", busy_u8, 0);
    chk("t4_prod", prod_u8, 16'h000F);
    run_op(0, 32'd2, 32'd3, 64'd6, 17, "u8_next");

    // Reset at E5 aborts the operation.
    d0 = ndone_u8;
    @(negedge clk);
    drive(0, 1'b1, 32'h55, 32'h66);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 1'b0, 32'h55, 32'h66);
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    nv_u8 = 0;
    chk("t5_busy", busy_u8, 0);
    chk("t5_pvalid", pv_u8, 0);
    chk("t5_done", done_u8, 0);
    chk("t5_prod", prod_u8, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_done", ndone_u8, d0);
    run_op(0, 32'h12, 32'h34, 64'h03A8, 17, "u8_after_rst");

    // Small random mixes on the 8-bit instances.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(0, a, b, {48'b0, mul8u(a[7:0], b[7:0])}, 17, "u8_rand");
      run_op(1, a, b, {48'b0, mul8s(a[7:0], b[7:0])}, 17, "s8_rand");
    end

    // 32-bit signed: corners, then 500 random operations.
    run_op(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 65, "s32_min_min");
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 65, "s32_m1_m1");
    run_op(2, 32'h7FFF_FFFF, 32'h8000_0000, mul32s(32'h7FFF_FFFF, 32'h8000_0000), 65, "s32_max_min");
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(2, a, b, mul32s(a, b), 65, "s32_rand");
    end

    chk("u8_sb_left", q_u8.size(), 0);
    chk("s8_sb_left", q_s8.size(), 0);
    chk("s32_sb_left", q_s32.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
